axi_rd_arbiter: RTL

- Shares the single CPU AXI4 read channel (AR/R) between the instruction cache (IC) and the data cache (DC).
- Grants one requester at a time and holds the grant for a whole burst, from AR accept through the R beat with rlast.
- Sits between the cache read-miss ports and the AXI master port that drives the AXI SRAM/DDR model.
- The write channels are not touched by this block.

---
 rtl/axi_rd_arbiter_if.sv | 65 ++++++
 rtl/axi_rd_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter_if.sv
// Bus bundle around axi_rd_arbiter: the IC and DC read-miss ports, the shared
// R data returned to both caches, and the downstream AXI4 read master (AR/R).
// modport master : the arbiter's view (it masters the downstream AXI port).
// modport slave  : the environment's view (caches plus the AXI memory model).
interface axi_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              ic_arvalid;
    logic              ic_arready;
    logic [ADDR_W-1:0] ic_araddr;
    logic [7:0]        ic_arlen;
    logic              ic_rvalid;
    logic              ic_rready;
    logic              ic_rlast;

    logic              dc_arvalid;
    logic              dc_arready;
    logic [ADDR_W-1:0] dc_araddr;
    logic [7:0]        dc_arlen;
    logic              dc_rvalid;
    logic              dc_rready;
    logic              dc_rlast;

    logic [DATA_W-1:0] up_rdata;
    logic [1:0]        up_rresp;

    logic              ax_arvalid;
    logic              ax_arready;
    logic [ADDR_W-1:0] ax_araddr;
    logic [7:0]        ax_arlen;
    logic [2:0]        ax_arsize;
    logic [1:0]        ax_arburst;
    logic [3:0]        ax_arid;
    logic              ax_rvalid;
    logic              ax_rready;
    logic [DATA_W-1:0] ax_rdata;
    logic [1:0]        ax_rresp;
    logic              ax_rlast;
    logic [3:0]        ax_rid;

    modport master (
        input  ic_arvalid, ic_araddr, ic_arlen, ic_rready,
        output ic_arready, ic_rvalid, ic_rlast,
        input  dc_arvalid, dc_araddr, dc_arlen, dc_rready,
        output dc_arready, dc_rvalid, dc_rlast,
        output up_rdata, up_rresp,
        output ax_arvalid, ax_araddr, ax_arlen, ax_arsize, ax_arburst, ax_arid,
        input  ax_arready,
        input  ax_rvalid, ax_rdata, ax_rresp, ax_rlast, ax_rid,
        output ax_rready
    );

    modport slave (
        output ic_arvalid, ic_araddr, ic_arlen, ic_rready,
        input  ic_arready, ic_rvalid, ic_rlast,
        output dc_arvalid, dc_araddr, dc_arlen, dc_rready,
        input  dc_arready, dc_rvalid, dc_rlast,
        input  up_rdata, up_rresp,
        input  ax_arvalid, ax_araddr, ax_arlen, ax_arsize, ax_arburst, ax_arid,
        output ax_arready,
        output ax_rvalid, ax_rdata, ax_rresp, ax_rlast, ax_rid,
        input  ax_rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 read channel between the I-cache and the
// D-cache. A grant is held for a whole burst, AR accept through rlast.
// Build option: define AXI_RD_ARB_RR_EN for round-robin on ties; otherwise
// DC always wins a tie.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no burst owned; pick a winner when any arvalid is high
// AR    | ax_arvalid held with latched addr/len/id until ax_arready
// R     | R beats routed to the owner until the beat with ax_rlast
module axi_rd_arbiter #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 64,
    parameter logic [3:0] ID_IC  = 4'd0,
    parameter logic [3:0] ID_DC  = 4'd1
) (
    input  logic                clock,
    input  logic                rst_n,
    axi_rd_arbiter_if.master    bus,
    output logic                err
);
    typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

    state_t            state_q;
    logic              gnt_ic_q;      // owner of the current/last burst, 1 = IC
    logic              ic_arready_q;
    logic              dc_arready_q;
    logic              ax_arvalid_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [7:0]        arlen_q;
    logic [3:0]        arid_q;
    logic [7:0]        beat_q;
    logic              err_q;

    logic              in_r;
    logic              beat;
    logic              win_ic;
    logic              err_d;
    logic              own_rready;
    logic [DATA_W-1:0] rdata_w;

    assign in_r       = (state_q == S_R);
    assign own_rready = gnt_ic_q ? bus.ic_rready : bus.dc_rready;
    assign beat       = in_r && bus.ax_rvalid && own_rready;

`ifdef AXI_RD_ARB_RR_EN
    // On a tie the requester that did not own the last burst wins.
    assign win_ic = bus.ic_arvalid && (!bus.dc_arvalid || !gnt_ic_q);
`else
    assign win_ic = bus.ic_arvalid && !bus.dc_arvalid;
`endif

    // Sticky protocol error: stray R beats, early/late rlast, wrong rid.
    always_comb begin
        err_d = err_q;
        if (bus.ax_rvalid && !in_r)
            err_d = 1'b1;
        if (beat && ((bus.ax_rlast && (beat_q != arlen_q)) ||
                     (!bus.ax_rlast && (beat_q == arlen_q)) ||
                     (bus.ax_rid != arid_q)))
            err_d = 1'b1;
    end

    // Arbitration FSM with registered arready pulses and AR fields.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            gnt_ic_q     <= 1'b0;
            ic_arready_q <= 1'b0;
            dc_arready_q <= 1'b0;
            ax_arvalid_q <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arid_q       <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            ic_arready_q <= 1'b0;
            dc_arready_q <= 1'b0;
            err_q        <= err_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.ic_arvalid || bus.dc_arvalid) begin
                        gnt_ic_q     <= win_ic;
                        ic_arready_q <= win_ic;
                        dc_arready_q <= !win_ic;
                        araddr_q     <= win_ic ? bus.ic_araddr : bus.dc_araddr;
                        arlen_q      <= win_ic ? bus.ic_arlen : bus.dc_arlen;
                        arid_q       <= win_ic ? ID_IC : ID_DC;
                        beat_q       <= '0;
                        ax_arvalid_q <= 1'b1;
                        state_q      <= S_AR;
                    end
                end
                S_AR: begin
                    if (bus.ax_arready) begin
                        ax_arvalid_q <= 1'b0;
                        state_q      <= S_R;
                    end
                end
                S_R: begin
                    if (beat) begin
                        if (bus.ax_rlast)
                            state_q <= S_IDLE;
                        else
                            beat_q <= beat_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rdata_w        = bus.ax_rdata;
    assign bus.up_rdata   = rdata_w;
    assign bus.up_rresp   = bus.ax_rresp;

    assign bus.ic_arready = ic_arready_q;
    assign bus.dc_arready = dc_arready_q;
    assign bus.ic_rvalid  = in_r && gnt_ic_q && bus.ax_rvalid;
    assign bus.ic_rlast   = in_r && gnt_ic_q && bus.ax_rlast;
    assign bus.dc_rvalid  = in_r && !gnt_ic_q && bus.ax_rvalid;
    assign bus.dc_rlast   = in_r && !gnt_ic_q && bus.ax_rlast;

    assign bus.ax_arvalid = ax_arvalid_q;
    assign bus.ax_araddr  = araddr_q;
    assign bus.ax_arlen   = arlen_q;
    assign bus.ax_arsize  = 3'b011;
    assign bus.ax_arburst = 2'b01;
    assign bus.ax_arid    = arid_q;
    assign bus.ax_rready  = in_r && own_rready;

    assign err = err_q;
endmodule
